vec_pack_sched: RTL
===================

Name: vec_pack_sched

Overview:
Two-requester scheduler in front of the vector pack datapath. The datapath computes out = {bswap32(a[63:32]), PAD_BYTE, b[23:0]}.
- Arbitrates between two valid/ready request ports.
- Feeds the granted (a, b) pair through the pack function.
- Returns the result through a one-entry registered output stage with a source tag.
- Sits between the front-end request queues and downstream consumers of packed words.

Parameters:
- PAD_BYTE, 8'h00, byte inserted at out[31:24].
- ROUND_ROBIN, 1. 1 means fair alternation; 0 means fixed priority, requester 0 always wins.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  64  requester 0 operand a; only a[63:32] is used.
- req0_b  in  64  requester 0 operand b; only b[23:0] is used.
- req0_ready  out  1  requester 0 accepted this cycle when valid & ready.
- req1_valid  in  1  requester 1 has an operand pair.
- req1_a  in  64  requester 1 operand a.
- req1_b  in  64  requester 1 operand b.
- req1_ready  out  1  requester 1 accepted this cycle when valid & ready.
- out_valid  out  1  out_data holds a result.
- out_data  out  64  packed result.
- out_src  out  1  index of the requester that produced out_data.
- out_ready  in  1  consumer accepts when out_valid & out_ready.

Behaviour:
Reset:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- While rst is high: out_valid=0, out_data=0, out_src=0, prio=0, req0_ready=0, req1_ready=0.
- Reset mid-operation discards any held result. No acceptance occurs in a cycle where rst is high.

Output stage state:
- EMPTY when out_valid=0; FULL when out_valid=1.
- can_load = !out_valid | out_ready.

Grant (combinational, same cycle):
- Only req0 valid: grant 0.
- Only req1 valid: grant 1.
- Both valid: grant prio when ROUND_ROBIN=1; grant 0 when ROUND_ROBIN=0.
- reqN_ready = can_load & (grant==N) & !rst.
- At most one ready is high per cycle.
- reqN_ready may be high while reqN_valid is low. It depends only on the grant, never on the requester's own valid beyond grant selection.

Accept (rising edge with a valid & ready pair):
- out_data <= {bswap32(a[63:32]), PAD_BYTE, b[23:0]}.
- bswap32(x) = {x[7:0], x[15:8], x[23:16], x[31:24]}.
- out_src <= grant; out_valid <= 1.
- If ROUND_ROBIN=1: prio <= ~grant.

Transitions:
- EMPTY with no request: stay EMPTY.
- EMPTY with accept: go FULL; latency is exactly 1 cycle from acceptance edge to out_valid.
- FULL & out_ready & accept: stay FULL with new data. This gives 1 result per cycle back-to-back.
- FULL & out_ready & no request: go EMPTY, out_valid <= 0.
- FULL & !out_ready: hold out_data and out_src stable, both readies 0, prio unchanged.

Other rules:
- Fairness (ROUND_ROBIN=1): with both requesters continuously valid and out_ready=1, grants alternate 0,1,0,1,...
- A lone requester may be granted every cycle.
- Bits a[31:0] and b[63:24] never affect outputs.

Optional Feature:
Macro VEC_PACK_SCHED_STATS_EN.
- Defined:
  - Adds output ports cnt0 and cnt1, each CNT_W wide.
  - Each counts accepted transactions of its requester.
  - Both counters reset to 0 and wrap modulo 2^CNT_W.
  - Adds input stats_clr. When stats_clr=1 on an edge, both counters load 0; this takes precedence over the increment in the same cycle.
- Undefined: neither port nor any counter logic exists. All other behaviour is identical.

Test Plan:
1. Reset then single request: req0_a=64'h11223344_DEADBEEF, req0_b=64'hFFFFFFFF_AABBCCDD, out_ready=1 -> next cycle out_valid=1, out_data=64'h44332211_00BBCCDD, out_src=0. With PAD_BYTE=8'h5A -> out_data=64'h44332211_5ABBCCDD.
2. Both requesters continuously valid, out_ready=1, 6 cycles, ROUND_ROBIN=1 -> out_src sequence 0,1,0,1,0,1. With ROUND_ROBIN=0 -> all 0 and req1_ready never high.
3. Backpressure: FULL with out_ready=0 for 4 cycles while req1_valid=1 -> out_data and out_src stable, req1_ready=0 throughout. Raise out_ready -> req1 accepted in that same cycle and its result appears the next cycle.
4. Drain: FULL, out_ready=1, no requests -> out_valid=0 next cycle. Subsequent idle cycles keep out_valid=0.
5. Reset mid-operation: out_valid=1 and prio=1, assert rst for 1 cycle -> out_valid=0, out_data=0, readies 0 during reset. First grant after reset with both valid goes to requester 0.
6. With VEC_PACK_SCHED_STATS_EN and CNT_W=4: 17 req0 accepts -> cnt0=1 (wrap). Assert stats_clr together with an accept -> cnt0=0 next cycle.

Source files
------------

// File: rtl/vec_pack_sched.sv
// vec_pack_sched: two-requester scheduler in front of the vector pack datapath.
// Each granted (a, b) pair is packed as
//   {bswap32(a[63:32]), PAD_BYTE, b[23:0]}
// and returned through a one-entry registered output stage tagged with the
// index of the requester that produced it.
//
// Ports:
//   clk                      clock, all state on the rising edge
//   rst                      synchronous reset, active-high
//   req0_valid/a/b, req0_ready   requester 0 valid/ready port
//   req1_valid/a/b, req1_ready   requester 1 valid/ready port
//   out_valid/data/src, out_ready  result port (src = producing requester)
//   stats_clr, cnt0, cnt1    accept counters, present only with
//                            VEC_PACK_SCHED_STATS_EN defined
//
// Optional feature macro: VEC_PACK_SCHED_STATS_EN
//
// state | meaning
// EMPTY | output stage holds no result (out_valid=0)
// FULL  | output stage holds a result  (out_valid=1)
module vec_pack_sched #(
  parameter logic [7:0] PAD_BYTE    = 8'h00,
  parameter int         ROUND_ROBIN = 1,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [63:0]      req0_a,
  input  logic [63:0]      req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [63:0]      req1_a,
  input  logic [63:0]      req1_b,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic             out_src,
`ifdef VEC_PACK_SCHED_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
`endif
  input  logic             out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        prio, prio_nxt;
  logic        grant, can_load, accept;
  logic [63:0] data_nxt;
  logic        src_nxt;
  logic [31:0] a_hi;
  logic [23:0] b_lo;

  // Operand bits outside the pack window never reach the outputs.
  logic unused_bits;
  assign unused_bits = ^{req0_a[31:0], req0_b[63:24], req1_a[31:0], req1_b[63:24]};

  assign out_valid = (state == FULL);
  assign can_load  = !out_valid || out_ready;
  // Requester 1 wins when it is alone, or when both ask and it holds priority.
  assign grant     = req1_valid && (!req0_valid || ((ROUND_ROBIN != 0) && prio));

  always_comb begin
    state_nxt  = state;
    data_nxt   = out_data;
    src_nxt    = out_src;
    prio_nxt   = prio;
    req0_ready = can_load && !grant && !rst;
    req1_ready = can_load && grant && !rst;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    a_hi       = grant ? req1_a[63:32] : req0_a[63:32];
    b_lo       = grant ? req1_b[23:0]  : req0_b[23:0];

    case (state)
      EMPTY: begin
        if (accept) state_nxt = FULL;
      end
      FULL: begin
        if (!accept && out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase

    if (accept) begin
      data_nxt = {a_hi[7:0], a_hi[15:8], a_hi[23:16], a_hi[31:24], PAD_BYTE, b_lo};
      src_nxt  = grant;
      if (ROUND_ROBIN != 0) prio_nxt = !grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= 1'b0;
      prio     <= 1'b0;
    end else begin
      state    <= state_nxt;
      out_data <= data_nxt;
      out_src  <= src_nxt;
      prio     <= prio_nxt;
    end
  end

`ifdef VEC_PACK_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (accept) begin
      if (grant) cnt1 <= cnt1 + 1'b1;
      else       cnt0 <= cnt0 + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
